// File: rtl/apb_multi_slave_master.sv
// APB4 master: accepts single transfers on a valid/ready port and runs SETUP/ACCESS
// against one of NUM_SLV slaves decoded from the top address bits, with optional timeout.
module apb_multi_slave_master #(
    parameter int NUM_SLV     = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                        pclk,
    input  logic                        preset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [ADDR_W-1:0]           cmd_addr,
    input  logic                        cmd_write,
    input  logic [DATA_W-1:0]           cmd_wdata,
    input  logic [DATA_W/8-1:0]         cmd_strb,
    input  logic [2:0]                  cmd_prot,
    output logic                        rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic                        rsp_timeout,
    output logic [ADDR_W-1:0]           paddr,
    output logic [NUM_SLV-1:0]          psel,
    output logic                        penable,
    output logic                        pwrite,
    output logic [DATA_W-1:0]           pwdata,
    output logic [DATA_W/8-1:0]         pstrb,
    output logic [2:0]                  pprot,
    input  logic [NUM_SLV*DATA_W-1:0]   prdata,
    input  logic [NUM_SLV-1:0]          pready,
    input  logic [NUM_SLV-1:0]          pslverr
);

    localparam int SEL_W  = $clog2(NUM_SLV);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t             state;
    logic [SEL_W-1:0]   idx;
    logic [CNT_W-1:0]   wait_cnt;

    logic [SEL_W-1:0]   dec_idx;
    logic               dec_ok;
    logic               sel_ready;
    logic               sel_err;
    logic [DATA_W-1:0]  sel_rdata;
    logic               to_hit;

    assign dec_idx   = cmd_addr[ADDR_W-1 -: SEL_W];
    assign dec_ok    = (int'(dec_idx) < NUM_SLV);

    // Only the latched slave's handshake and data are ever looked at.
    assign sel_ready = pready[idx];
    assign sel_err   = pslverr[idx];
    assign sel_rdata = prdata[int'(idx)*DATA_W +: DATA_W];

    // The counter holds the number of stalled ACCESS cycles already seen, so the
    // abort fires on the TIMEOUT_CYC-th stalled cycle.
    assign to_hit    = (TIMEOUT_CYC != 0) && (wait_cnt == TO_LAST);

    // Gated with reset so the port reads not-ready while reset is held.
    assign cmd_ready = (state == IDLE) && !preset;

    // NOTE: registers are updated only with <=, so every branch below sees pre-edge values.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state       <= IDLE;
            idx         <= '0;
            wait_cnt    <= '0;
            paddr       <= '0;
            psel        <= '0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            pstrb       <= '0;
            pprot       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (dec_ok) begin
                            state    <= SETUP;
                            idx      <= dec_idx;
                            wait_cnt <= '0;
                            psel     <= NUM_SLV'(1) << dec_idx;
                            paddr    <= cmd_addr;
                            pwrite   <= cmd_write;
                            pwdata   <= cmd_wdata;
                            pstrb    <= cmd_write ? cmd_strb : STRB_W'(0);
                            pprot    <= cmd_prot;
                        end else begin
                            // Unmapped address: answer straight away, APB stays untouched.
                            state       <= RESP;
                            rsp_valid   <= 1'b1;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b0;
                            rsp_rdata   <= '0;
                        end
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
                end
                ACCESS: begin
                    if (sel_ready) begin
                        state       <= RESP;
                        psel        <= '0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= sel_err;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= (!pwrite && !sel_err) ? sel_rdata : '0;
                    end else if (to_hit) begin
                        state       <= RESP;
                        psel        <= '0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_multi_slave_master.sv
// Directed bench for apb_multi_slave_master: a 4-slave instance with a small slave model and
// a scoreboard on the response port, plus a 3-slave instance for the decode-error case.
module tb_apb_multi_slave_master;

    logic pclk = 1'b0;
    logic preset = 1'b1;
    always #5 pclk = ~pclk;

    // 4-slave instance
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata, paddr, pwdata;
    logic [3:0]  psel, pstrb;
    logic        penable, pwrite;
    logic [2:0]  pprot;
    logic [127:0] prdata;
    logic [3:0]  pready, pslverr;

    // 3-slave instance
    logic        d3_cmd_valid, d3_cmd_ready;
    logic [31:0] d3_cmd_addr;
    logic        d3_rsp_valid, d3_rsp_err, d3_rsp_timeout;
    logic [31:0] d3_rsp_rdata, d3_paddr, d3_pwdata;
    logic [2:0]  d3_psel;
    logic [3:0]  d3_pstrb;
    logic        d3_penable, d3_pwrite;
    logic [2:0]  d3_pprot;

    // Slave model: pready low for wait_n ACCESS cycles, forever for stalled slaves.
    logic [3:0] stall;
    int         wait_n;
    int         acc_cnt;

    assign prdata  = {32'h3333_3333, 32'h2222_2222, 32'hCAFE_BABE, 32'h1111_0000};
    assign pready  = (acc_cnt >= wait_n) ? ~stall : 4'h0;

    always @(posedge pclk or posedge preset) begin
        if (preset)       acc_cnt <= 0;
        else if (penable) acc_cnt <= acc_cnt + 1;
        else              acc_cnt <= 0;
    end

    apb_multi_slave_master #(.NUM_SLV(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) u_dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_write(cmd_write),
        .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    apb_multi_slave_master #(.NUM_SLV(3), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) u_dut3 (
        .pclk(pclk), .preset(preset),
        .cmd_valid(d3_cmd_valid), .cmd_ready(d3_cmd_ready), .cmd_addr(d3_cmd_addr), .cmd_write(1'b0),
        .cmd_wdata(32'h0), .cmd_strb(4'h0), .cmd_prot(3'b000),
        .rsp_valid(d3_rsp_valid), .rsp_rdata(d3_rsp_rdata), .rsp_err(d3_rsp_err),
        .rsp_timeout(d3_rsp_timeout),
        .paddr(d3_paddr), .psel(d3_psel), .penable(d3_penable), .pwrite(d3_pwrite), .pwdata(d3_pwdata),
        .pstrb(d3_pstrb), .pprot(d3_pprot),
        .prdata({32'h5555_5555, 32'h4444_4444, 32'h3030_3030}), .pready(3'b111), .pslverr(3'b000)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        tout;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;

    function automatic rsp_t mk(input logic [31:0] r, input logic e, input logic t);
        mk = '{rdata: r, err: e, tout: t};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every response must match the oldest outstanding expectation.
    always @(negedge pclk) begin
        if (rsp_valid === 1'b1) begin
            check("rsp_expected", 64'(exp_q.size() != 0), 64'h1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("rsp_rdata",   64'(rsp_rdata),   64'(mon_e.rdata));
                check("rsp_err",     64'(rsp_err),     64'(mon_e.err));
                check("rsp_timeout", 64'(rsp_timeout), 64'(mon_e.tout));
            end
        end
    end

    // Present one command and hold it until it is taken; returns just after the accept edge.
    task automatic do_cmd(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, input logic [2:0] p);
        int n;
        n = 0;
        cmd_addr  = a;
        cmd_write = w;
        cmd_wdata = d;
        cmd_strb  = s;
        cmd_prot  = p;
        cmd_valid = 1'b1;
        @(negedge pclk);
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge pclk);
            n++;
        end
        check("accept_in_time", 64'(cmd_ready), 64'h1);
        @(posedge pclk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Called at the SETUP sample point; returns at the first sample with penable low.
    task automatic wait_access(output int n, output logic stable);
        logic [31:0] a0, d0;
        logic [3:0]  s0;
        a0 = paddr;
        d0 = pwdata;
        s0 = psel;
        n = 0;
        stable = 1'b1;
        @(negedge pclk);
        while (penable === 1'b1 && n < 40) begin
            if (paddr !== a0 || pwdata !== d0 || psel !== s0) stable = 1'b0;
            n++;
            @(negedge pclk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        logic        st;
        int          t_acc [3];
        int          accepts;
        int          cyc;
        int          rsp_seen;

        cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
        d3_cmd_valid = 1'b0; d3_cmd_addr = '0;
        stall = 4'h0; wait_n = 0; pslverr = 4'h0;

        // Reset values while reset is held
        #3;
        check("rst_psel",      64'(psel),      64'h0);
        check("rst_penable",   64'(penable),   64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'h0);
        @(posedge pclk); @(posedge pclk); #1;
        preset = 1'b0;
        @(negedge pclk);
        check("rel_cmd_ready", 64'(cmd_ready), 64'h1);
        @(posedge pclk); #1;

        // Zero-wait write to slave 0
        exp_q.push_back(mk(32'h0, 1'b0, 1'b0));
        do_cmd(32'h0000_0004, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010);
        @(negedge pclk);
        check("wr_setup_psel",    64'(psel),    64'h1);
        check("wr_setup_penable", 64'(penable), 64'h0);
        check("wr_paddr",         64'(paddr),   64'h4);
        check("wr_pwdata",        64'(pwdata),  64'hDEAD_BEEF);
        check("wr_pstrb",         64'(pstrb),   64'hF);
        check("wr_pwrite",        64'(pwrite),  64'h1);
        check("wr_pprot",         64'(pprot),   64'h2);
        check("wr_cmd_ready_busy", 64'(cmd_ready), 64'h0);
        @(negedge pclk);
        check("wr_access_psel",    64'(psel),    64'h1);
        check("wr_access_penable", 64'(penable), 64'h1);
        @(negedge pclk);
        check("wr_rsp_valid", 64'(rsp_valid), 64'h1);
        check("wr_rsp_psel",  64'(psel),      64'h0);
        check("wr_rsp_pen",   64'(penable),   64'h0);
        @(posedge pclk); #1;

        // Read from slave 1 with three wait states
        wait_n = 3;
        exp_q.push_back(mk(32'hCAFE_BABE, 1'b0, 1'b0));
        do_cmd(32'h4000_0008, 1'b0, 32'h0, 4'hF, 3'b000);
        @(negedge pclk);
        check("rd_setup_psel",  64'(psel),   64'h2);
        check("rd_setup_pstrb", 64'(pstrb),  64'h0);
        check("rd_setup_pwrite", 64'(pwrite), 64'h0);
        wait_access(n, st);
        check("rd_access_cycles", 64'(n),  64'h4);
        check("rd_paddr_stable",  64'(st), 64'h1);
        check("rd_rsp_valid",     64'(rsp_valid), 64'h1);
        @(posedge pclk); #1;
        wait_n = 0;

        // Slave 2 never ready: abort after 16 ACCESS cycles
        stall = 4'b0100;
        exp_q.push_back(mk(32'h0, 1'b1, 1'b1));
        do_cmd(32'h8000_0000, 1'b0, 32'h0, 4'h0, 3'b000);
        @(negedge pclk);
        wait_access(n, st);
        check("to_access_cycles", 64'(n),         64'd16);
        check("to_rsp_valid",     64'(rsp_valid), 64'h1);
        check("to_psel",          64'(psel),      64'h0);
        @(posedge pclk); #1;
        stall = 4'h0;

        // Next command after the timeout completes normally
        exp_q.push_back(mk(32'h2222_2222, 1'b0, 1'b0));
        do_cmd(32'h8000_0004, 1'b0, 32'h0, 4'h0, 3'b000);
        @(negedge pclk);
        wait_access(n, st);
        check("post_to_access_cycles", 64'(n),         64'h1);
        check("post_to_rsp_valid",     64'(rsp_valid), 64'h1);
        @(posedge pclk); #1;

        // PSLVERR from slave 3 on a write
        pslverr = 4'b1000;
        exp_q.push_back(mk(32'h0, 1'b1, 1'b0));
        do_cmd(32'hC000_0000, 1'b1, 32'h1234_5678, 4'h3, 3'b000);
        repeat (3) @(negedge pclk);
        check("slverr_rsp_valid", 64'(rsp_valid), 64'h1);
        @(posedge pclk); #1;

        // Back-to-back reads to slave 3; other slaves erroring and stalled must be ignored
        pslverr = 4'b0111;
        stall   = 4'b0111;
        cmd_addr = 32'hC000_0010; cmd_write = 1'b0; cmd_strb = 4'h0; cmd_prot = 3'b000;
        cmd_valid = 1'b1;
        accepts = 0;
        cyc = 0;
        while (accepts < 3 && cyc < 40) begin
            @(negedge pclk);
            if (cmd_ready === 1'b1) begin
                exp_q.push_back(mk(32'h3333_3333, 1'b0, 1'b0));
                t_acc[accepts] = cyc;
                accepts++;
            end
            cyc++;
        end
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        check("b2b_accepts", 64'(accepts),             64'h3);
        check("b2b_gap0",    64'(t_acc[1] - t_acc[0]), 64'h4);
        check("b2b_gap1",    64'(t_acc[2] - t_acc[1]), 64'h4);
        repeat (4) @(negedge pclk);
        @(posedge pclk); #1;
        pslverr = 4'h0;
        stall   = 4'h0;

        // Reset in the middle of a stalled ACCESS: no response afterwards
        stall = 4'b0010;
        do_cmd(32'h4000_0000, 1'b0, 32'h0, 4'h0, 3'b000);
        @(negedge pclk);
        @(negedge pclk);
        check("mid_in_access", 64'(penable), 64'h1);
        #2;
        preset = 1'b1;
        #1;
        check("mid_rst_psel",      64'(psel),      64'h0);
        check("mid_rst_penable",   64'(penable),   64'h0);
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("mid_rst_cmd_ready", 64'(cmd_ready), 64'h0);
        @(posedge pclk); @(posedge pclk); #1;
        preset = 1'b0;
        stall  = 4'h0;
        @(negedge pclk);
        check("mid_rel_cmd_ready", 64'(cmd_ready), 64'h1);
        rsp_seen = 0;
        repeat (6) begin
            @(negedge pclk);
            if (rsp_valid === 1'b1) rsp_seen++;
        end
        check("mid_no_rsp", 64'(rsp_seen), 64'h0);
        @(posedge pclk); #1;

        // Three-slave instance: address in the unmapped fourth quarter
        d3_cmd_addr  = 32'hC000_0000;
        d3_cmd_valid = 1'b1;
        @(negedge pclk);
        check("dec_cmd_ready", 64'(d3_cmd_ready), 64'h1);
        @(posedge pclk); #1;
        d3_cmd_valid = 1'b0;
        @(negedge pclk);
        check("dec_rsp_valid",   64'(d3_rsp_valid),   64'h1);
        check("dec_rsp_err",     64'(d3_rsp_err),     64'h1);
        check("dec_rsp_timeout", 64'(d3_rsp_timeout), 64'h0);
        check("dec_rsp_rdata",   64'(d3_rsp_rdata),   64'h0);
        check("dec_psel",        64'(d3_psel),        64'h0);
        @(negedge pclk);
        check("dec_rsp_done", 64'(d3_rsp_valid), 64'h0);
        check("dec_psel_idle", 64'(d3_psel),     64'h0);

        // Three-slave instance: valid read from slave 2
        @(posedge pclk); #1;
        d3_cmd_addr  = 32'h8000_0000;
        d3_cmd_valid = 1'b1;
        @(posedge pclk); #1;
        d3_cmd_valid = 1'b0;
        @(negedge pclk);
        check("d3_setup_psel", 64'(d3_psel), 64'h4);
        repeat (2) @(negedge pclk);
        check("d3_rsp_valid", 64'(d3_rsp_valid), 64'h1);
        check("d3_rsp_rdata", 64'(d3_rsp_rdata), 64'h5555_5555);
        check("d3_rsp_err",   64'(d3_rsp_err),   64'h0);

        repeat (2) @(negedge pclk);
        check("queue_drained", 64'(exp_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
